// File: rtl/jstk_spi_responder.sv
// SPI mode-0 joystick responder: streams X/Y/buttons out while capturing a 40-bit LED command.
// Optional bad-length reporting on frame_err_o is enabled by defining JSTK_SPI_RESPONDER_FRAME_ERR_EN.
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        spi_cs_i,
  input  logic        spi_sck_i,
  input  logic        spi_sd_i,
  output logic        spi_sd_o,
  input  logic [9:0]  position_x_i,
  input  logic [9:0]  position_y_i,
  input  logic [1:0]  buttons_i,
  output logic [7:0]  cmd_o,
  output logic [23:0] rgb_o,
  output logic        valid_o,
  output logic        frame_err_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, sd_sync_q, fill_q;
  logic                   cs_prev_q, sck_prev_q, armed_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      sd_sync_q  <= '0;
      fill_q     <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], spi_sd_i};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      // Only a CS low preceded by a genuine post-reset high counts as a frame start.
      if (fill_q[SYNC_STAGES-1] && cs_sync_q[SYNC_STAGES-1])
        armed_q <= 1'b1;
    end
  end

  logic cs_s, sck_s, sd_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sd_s     = sd_sync_q[SYNC_STAGES-1];
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  state_t      state_q;
  logic [39:0] tx_q, rx_q, tx_frame_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        sd_o_q, pend_q, valid_q, frame_err_q;
  logic [7:0]  cmd_q;
  logic [23:0] rgb_q;

  assign tx_frame_d = {position_x_i[7:0], 6'b0, position_x_i[9:8],
                       position_y_i[7:0], 6'b0, position_y_i[9:8],
                       6'b0, buttons_i};
  assign bit_cnt_d  = (bit_cnt_q == 6'd41) ? 6'd41 : bit_cnt_q + 6'd1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      sd_o_q      <= 1'b0;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_q       <= '0;
      rgb_q       <= '0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sd_o_q <= 1'b0;
          if (cs_fall || pend_q) begin
            state_q   <= SHIFT;
            pend_q    <= 1'b0;
            sd_o_q    <= tx_frame_d[39];
            tx_q      <= {tx_frame_d[38:0], 1'b0};
            rx_q      <= '0;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q <= CHECK;
            sd_o_q  <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_q      <= {rx_q[38:0], sd_s};
              bit_cnt_q <= bit_cnt_d;
            end
            // Zeros shift in behind the frame, so the line drops to 0 after bit 39.
            if (sck_fall) begin
              sd_o_q <= tx_q[39];
              tx_q   <= {tx_q[38:0], 1'b0};
            end
          end
        end
        CHECK: begin
          state_q <= IDLE;
          sd_o_q  <= 1'b0;
          if (cs_fall)
            pend_q <= 1'b1;
          if (bit_cnt_q == 6'd40) begin
            cmd_q <= rx_q[39:32];
            if (rx_q[39:32] == 8'h84) begin
              rgb_q   <= rx_q[31:8];
              valid_q <= 1'b1;
            end
          end else begin
`ifdef JSTK_SPI_RESPONDER_FRAME_ERR_EN
            frame_err_q <= 1'b1;
`else
            frame_err_q <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          sd_o_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spi_sd_o    = sd_o_q;
  assign cmd_o       = cmd_q;
  assign rgb_o       = rgb_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;

endmodule
